// File: rtl/cam_match_array_if.sv
// Host-side bundle for cam_match_array: write/invalidate/search controls and match/occupancy results.
// Optional CAM_MASK_EN adds search_mask_i (per-bit don't-care on the search compare).
interface cam_match_array_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  write_i;
  logic [4:0]            write_index_i;
  logic [DATA_WIDTH-1:0] write_data_i;
  logic                  invalidate_i;
  logic                  search_i;
  logic [DATA_WIDTH-1:0] search_data_i;
`ifdef CAM_MASK_EN
  logic [DATA_WIDTH-1:0] search_mask_i;
`endif
  logic [31:0]           match_o;
  logic                  match_valid_o;
  logic [5:0]            count_o;
  logic                  full_o;

  // Handshake: there is no backpressure. Every cycle with search_i high is
  // accepted and yields exactly one match_valid_o pulse one edge later.
  // write_i / invalidate_i are likewise always accepted; write_i wins over
  // invalidate_i when both are high.
  modport master (
`ifdef CAM_MASK_EN
    output search_mask_i,
`endif
    output write_i, write_index_i, write_data_i, invalidate_i,
    output search_i, search_data_i,
    input  match_o, match_valid_o, count_o, full_o
  );

  modport slave (
`ifdef CAM_MASK_EN
    input  search_mask_i,
`endif
    input  write_i, write_index_i, write_data_i, invalidate_i,
    input  search_i, search_data_i,
    output match_o, match_valid_o, count_o, full_o
  );
endinterface

// File: rtl/cam_match_array.sv
// 32-entry CAM storage with parallel compare, registered match vector and occupancy count.
// Define CAM_MASK_EN to enable the per-bit search mask (bits set in the mask are don't-care).
module cam_match_array #(
  parameter int DATA_WIDTH = 32
) (
  input logic               clk_i,
  input logic               rst_n_i,
  cam_match_array_if.slave  bus
);
  localparam int ENTRIES = 32;

  logic [DATA_WIDTH-1:0] data_q [ENTRIES];
  logic [ENTRIES-1:0]    valid_q, valid_d;
  logic [ENTRIES-1:0]    hit;
  logic [31:0]           match_q, match_d;
  logic                  match_valid_q, match_valid_d;
  logic [5:0]            count_q, count_d;
  logic                  full_q, full_d;
  logic [DATA_WIDTH-1:0] care_mask;

`ifdef CAM_MASK_EN
  assign care_mask = ~bus.search_mask_i;
`else
  assign care_mask = '1;
`endif

  // Compare uses the pre-edge contents, so a same-cycle write is not seen.
  always_comb begin
    hit = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      hit[i] = valid_q[i] && (((data_q[i] ^ bus.search_data_i) & care_mask) == '0);
    end
  end

  always_comb begin
    valid_d       = valid_q;
    count_d       = count_q;
    match_d       = match_q;
    match_valid_d = bus.search_i;
    if (bus.write_i) begin
      valid_d[bus.write_index_i] = 1'b1;
      if (!valid_q[bus.write_index_i]) count_d = count_q + 6'd1;
    end else if (bus.invalidate_i) begin
      valid_d[bus.write_index_i] = 1'b0;
      if (valid_q[bus.write_index_i]) count_d = count_q - 6'd1;
    end
    if (bus.search_i) match_d = hit;
    full_d = (count_d == 6'd32);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      valid_q       <= '0;
      match_q       <= '0;
      match_valid_q <= 1'b0;
      count_q       <= '0;
      full_q        <= 1'b0;
    end else begin
      valid_q       <= valid_d;
      match_q       <= match_d;
      match_valid_q <= match_valid_d;
      count_q       <= count_d;
      full_q        <= full_d;
    end
  end

  // Word storage carries no reset; the valid bits alone decide visibility.
  always_ff @(posedge clk_i) begin
    if (rst_n_i && bus.write_i) data_q[bus.write_index_i] <= bus.write_data_i;
  end

  assign bus.match_o       = match_q;
  assign bus.match_valid_o = match_valid_q;
  assign bus.count_o       = count_q;
  assign bus.full_o        = full_q;
endmodule
